ddr3_native_port_arbiter: RTL and testbench

//  Shares the DDR3 controller's single native command port among NUM_PORTS requesters.
//  It sits in the mem_clk domain (DDR3 clk_out, 1:4 rate), between the AHB-to-mem adapter

---
 rtl/ddr3_arb_pkg.sv | 32 +++
 rtl/ddr3_arb_tag_fifo.sv | 70 +++++++
 rtl/ddr3_native_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_ddr3_native_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_arb_pkg
// Description : Shared types and constants for the DDR3 native-port arbiter.
//               DDR3 native command encodings, the arbiter state enum and the
//               control part of the single-entry command register.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr3_arb_pkg;

    // Native command encodings of the DDR3 controller
    localparam logic [2:0] DDR_CMD_WR = 3'b000;
    localparam logic [2:0] DDR_CMD_RD = 3'b001;

    // Widest port index needed for the largest supported port count (8)
    localparam int c_MAX_PORT_W = 3;

    typedef enum logic [0:0] {
        WAIT_CALIB = 1'b0,
        RUN        = 1'b1
    } arb_state_t;

    // Control fields of the command register; the address, data and mask
    // payload are sized by the top-level parameters and held alongside.
    typedef struct packed {
        logic                    valid;
        logic                    write;
        logic [c_MAX_PORT_W-1:0] port;
    } cmd_ctl_t;

endpackage : ddr3_arb_pkg
`default_nettype wire

// File: rtl/ddr3_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_arb_tag_fifo
// Description : Synchronous FIFO of read tags (issuing port ids). Read data
//               from the controller returns in order, so the head of this
//               FIFO always names the port that owns the next returning beat.
// Ports       : clk/rst      - clock, synchronous active-high reset
//               i_push/i_push_tag - enqueue a tag
//               i_pop        - dequeue the head (ignored when empty)
//               o_pop_tag    - current head tag
//               o_count/o_full/o_empty - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_arb_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [TAG_W-1:0] i_push_tag,
    input  logic             i_pop,
    output logic [TAG_W-1:0] o_pop_tag,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    // A push into a full FIFO is legal only when the head leaves this cycle
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_pop_tag = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_tag;
        end
    end

    // Pointers wrap naturally: DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : ddr3_arb_tag_fifo
`default_nettype wire

// File: rtl/ddr3_native_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_native_port_arbiter
// Description : Shares the DDR3 controller's native command port among
//               NUM_PORTS requesters in the mem_clk domain. Port 0 has fixed
//               priority bounded by a starvation guard; the other ports are
//               served round-robin. A tag FIFO routes in-order read data back
//               to the issuing port.
// Ports       : mem_clk/mem_rst      - clock, synchronous active-high reset
//               req_*                - per-port command interface, packed
//               rsp_valid/rsp_rdata  - one-hot read strobe, shared read data
//               ddr_*                - DDR3 controller native interface
//               err_unexp_rd         - sticky: read data with no tag pending
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_native_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int RD_TAG_DEPTH = 8,
    parameter int PORT0_PRIO   = 1,
    parameter int MAX_WAIT     = 4,
    localparam int BE_W        = DATA_W / 8
) (
    input  logic                      mem_clk,
    input  logic                      mem_rst,
    input  logic [NUM_PORTS-1:0]      req_valid,
    input  logic [NUM_PORTS-1:0]      req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    input  logic [NUM_PORTS*BE_W-1:0] req_wbe,
    output logic [NUM_PORTS-1:0]      req_ready,
    output logic [NUM_PORTS-1:0]      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    input  logic                      ddr_calib_done,
    input  logic                      ddr_cmd_ready,
    input  logic                      ddr_wr_data_rdy,
    output logic [2:0]                ddr_cmd,
    output logic                      ddr_cmd_en,
    output logic [ADDR_W-1:0]         ddr_addr,
    output logic [DATA_W-1:0]         ddr_wr_data,
    output logic                      ddr_wr_data_en,
    output logic                      ddr_wr_data_end,
    output logic [BE_W-1:0]           ddr_wr_data_mask,
    input  logic [DATA_W-1:0]         ddr_rd_data,
    input  logic                      ddr_rd_data_valid,
    output logic                      err_unexp_rd
);

    localparam int c_TAG_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_CNT_W  = $clog2(RD_TAG_DEPTH) + 1;
    localparam int c_WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    // Cyclic index helpers for the round-robin search and pointer update
    function automatic int f_wrap(input int v);
        return (v >= NUM_PORTS) ? v - NUM_PORTS : v;
    endfunction

    function automatic int f_next(input int v);
        if (v + 1 >= NUM_PORTS) return (PORT0_PRIO != 0) ? 1 : 0;
        return v + 1;
    endfunction

    arb_state_t           r_state;
    cmd_ctl_t             r_ctl;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [BE_W-1:0]      r_mask;
    logic [c_TAG_W-1:0]   r_rr_ptr;
    logic [c_WAIT_W-1:0]  r_wait_cnt;
    logic [NUM_PORTS-1:0] r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_rdata;
    logic                 r_err;

    logic                 w_fire;
    logic                 w_push;
    logic                 w_pop;
    logic [c_TAG_W-1:0]   w_pop_tag;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_full;
    logic                 w_empty;
    logic [c_CNT_W:0]     w_cnt_after;
    logic                 w_rd_ok;
    logic [NUM_PORTS-1:0] w_elig;
    logic                 w_others;
    logic                 w_can_grant;
    logic                 w_p0_first;
    logic                 w_rr_found;
    logic [c_TAG_W-1:0]   w_rr_idx;
    logic [c_TAG_W-1:0]   w_win_idx;
    logic                 w_grant;

    assign w_fire  = r_ctl.valid & ddr_cmd_ready & ddr_wr_data_rdy;
    assign w_push  = w_fire & ~r_ctl.write;
    assign w_pop   = ddr_rd_data_valid & ~w_empty;

    ddr3_arb_tag_fifo #(
        .DEPTH (RD_TAG_DEPTH),
        .TAG_W (c_TAG_W)
    ) u_tag_fifo (
        .clk        (mem_clk),
        .rst        (mem_rst),
        .i_push     (w_push),
        .i_push_tag (c_TAG_W'(r_ctl.port)),
        .i_pop      (w_pop),
        .o_pop_tag  (w_pop_tag),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // A read granted now only reaches the FIFO when it fires, and no grant is
    // given while the register holds an unfired command, so occupancy after
    // this cycle's push/pop bounds every read that can be in flight.
    assign w_cnt_after = (c_CNT_W+1)'(w_count) + (c_CNT_W+1)'(w_push)
                       - (c_CNT_W+1)'(w_pop);
    assign w_rd_ok     = w_full ? (w_pop & ~w_push)
                                : (w_cnt_after < (c_CNT_W+1)'(RD_TAG_DEPTH));
    assign w_elig      = req_valid & (req_write | {NUM_PORTS{w_rd_ok}});
    assign w_others    = |w_elig[NUM_PORTS-1:1];
    assign w_can_grant = (r_state == RUN) & (~r_ctl.valid | w_fire);
    assign w_p0_first  = (PORT0_PRIO != 0) & w_elig[0]
                       & (r_wait_cnt < c_WAIT_W'(MAX_WAIT));

    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!w_rr_found && w_elig[c_TAG_W'(f_wrap(int'(r_rr_ptr) + k))]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = c_TAG_W'(f_wrap(int'(r_rr_ptr) + k));
            end
        end
    end

    assign w_win_idx = w_p0_first ? '0 : w_rr_idx;
    assign w_grant   = w_can_grant & (w_p0_first | w_rr_found);

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ready
            assign req_ready[p] = w_grant & (w_win_idx == c_TAG_W'(p));
        end
    endgenerate

    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            r_state     <= WAIT_CALIB;
            r_ctl       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
            r_rr_ptr    <= c_TAG_W'(1);
            r_wait_cnt  <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                WAIT_CALIB: if (ddr_calib_done) r_state <= RUN;
                RUN:        r_state <= RUN;
                default:    r_state <= WAIT_CALIB;
            endcase

            if (w_fire) r_ctl.valid <= 1'b0;

            if (w_grant) begin
                r_ctl.valid <= 1'b1;
                r_ctl.write <= req_write[w_win_idx];
                r_ctl.port  <= c_MAX_PORT_W'(w_win_idx);
                r_addr      <= req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
                r_wdata     <= req_wdata[int'(w_win_idx)*DATA_W +: DATA_W];
                r_mask      <= ~req_wbe[int'(w_win_idx)*BE_W +: BE_W];
                // Under pure round-robin port 0 also advances the pointer
                if ((w_win_idx != '0) || (PORT0_PRIO == 0)) begin
                    r_rr_ptr   <= c_TAG_W'(f_next(int'(w_win_idx)));
                    r_wait_cnt <= '0;
                end else if (w_others) begin
                    if (r_wait_cnt < c_WAIT_W'(MAX_WAIT))
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                end else begin
                    r_wait_cnt <= '0;
                end
            end

            r_rsp_valid <= '0;
            if (w_pop) begin
                r_rsp_valid <= NUM_PORTS'(1) << w_pop_tag;
                r_rsp_rdata <= ddr_rd_data;
            end
            if (ddr_rd_data_valid & w_empty) r_err <= 1'b1;
        end
    end

    assign ddr_cmd_en       = w_fire;
    assign ddr_cmd          = (r_ctl.valid & ~r_ctl.write) ? DDR_CMD_RD : DDR_CMD_WR;
    assign ddr_addr         = r_addr;
    assign ddr_wr_data      = r_wdata;
    assign ddr_wr_data_mask = r_mask;
    assign ddr_wr_data_en   = w_fire & r_ctl.write;
    assign ddr_wr_data_end  = ddr_wr_data_en;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_rdata        = r_rsp_rdata;
    assign err_unexp_rd     = r_err;

endmodule : ddr3_native_port_arbiter
`default_nettype wire

// File: tb/tb_ddr3_native_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_native_port_arbiter
// Description : Directed bench for ddr3_native_port_arbiter. Stimulus pushes
//               expected DDR commands and read responses into queues; two
//               monitors pop and compare whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_native_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int BW = DW / 8;

    logic             mem_clk = 1'b0;
    logic             mem_rst;
    logic [NP-1:0]    req_valid;
    logic [NP-1:0]    req_write;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic [NP*BW-1:0] req_wbe;
    logic [NP-1:0]    req_ready;
    logic [NP-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             ddr_calib_done;
    logic             ddr_cmd_ready;
    logic             ddr_wr_data_rdy;
    logic [2:0]       ddr_cmd;
    logic             ddr_cmd_en;
    logic [AW-1:0]    ddr_addr;
    logic [DW-1:0]    ddr_wr_data;
    logic             ddr_wr_data_en;
    logic             ddr_wr_data_end;
    logic [BW-1:0]    ddr_wr_data_mask;
    logic [DW-1:0]    ddr_rd_data;
    logic             ddr_rd_data_valid;
    logic             err_unexp_rd;

    always #5 mem_clk = ~mem_clk;

    ddr3_native_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW),
        .RD_TAG_DEPTH(8), .PORT0_PRIO(1), .MAX_WAIT(4)
    ) dut (
        .mem_clk(mem_clk), .mem_rst(mem_rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wbe(req_wbe), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ddr_calib_done(ddr_calib_done), .ddr_cmd_ready(ddr_cmd_ready),
        .ddr_wr_data_rdy(ddr_wr_data_rdy), .ddr_cmd(ddr_cmd),
        .ddr_cmd_en(ddr_cmd_en), .ddr_addr(ddr_addr), .ddr_wr_data(ddr_wr_data),
        .ddr_wr_data_en(ddr_wr_data_en), .ddr_wr_data_end(ddr_wr_data_end),
        .ddr_wr_data_mask(ddr_wr_data_mask), .ddr_rd_data(ddr_rd_data),
        .ddr_rd_data_valid(ddr_rd_data_valid), .err_unexp_rd(err_unexp_rd)
    );

    typedef struct {
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] mask;
    } exp_cmd_t;

    typedef struct {
        logic [NP-1:0] port;
        logic [DW-1:0] data;
    } exp_rsp_t;

    exp_cmd_t exp_cmd_q[$];
    exp_rsp_t exp_rsp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Command monitor
    always @(negedge mem_clk) begin
        exp_cmd_t e;
        if (ddr_cmd_en === 1'b1) begin
            if (exp_cmd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_cmd actual=cmd_en addr=%0h required=idle t=%0t", ddr_addr, $time);
            end else begin
                e = exp_cmd_q.pop_front();
                check("cmd_op", 128'(ddr_cmd), 128'(e.cmd));
                check("cmd_addr", 128'(ddr_addr), 128'(e.addr));
                if (e.cmd == 3'b000) begin
                    check("wr_data", ddr_wr_data, e.data);
                    check("wr_mask", 128'(ddr_wr_data_mask), 128'(e.mask));
                    check("wr_en_end", 128'({ddr_wr_data_en, ddr_wr_data_end}), 128'(2'b11));
                end else begin
                    check("rd_wr_en", 128'({ddr_wr_data_en, ddr_wr_data_end}), 128'(2'b00));
                end
            end
        end
    end

    // Response monitor
    always @(negedge mem_clk) begin
        exp_rsp_t r;
        if (!mem_rst && rsp_valid !== '0) begin
            if (exp_rsp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rsp actual=%b required=00 t=%0t", rsp_valid, $time);
            end else begin
                r = exp_rsp_q.pop_front();
                check("rsp_port", 128'(rsp_valid), 128'(r.port));
                check("rsp_data", rsp_rdata, r.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_port(input int p, input logic v, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_valid[p]         = v;
        req_write[p]         = w;
        req_addr[p*AW +: AW] = a;
        req_wdata[p*DW +: DW] = d;
        req_wbe[p*BW +: BW]  = be;
    endtask

    // Check req_ready against the hand-computed grant, record the expected
    // DDR command for the granted port, then advance to just after the edge.
    task automatic tick(input logic [NP-1:0] exp, input string name);
        exp_cmd_t e;
        @(negedge mem_clk);
        check(name, 128'(req_ready), 128'(exp));
        for (int p = 0; p < NP; p++) begin
            if (exp[p]) begin
                e.cmd  = req_write[p] ? 3'b000 : 3'b001;
                e.addr = req_addr[p*AW +: AW];
                e.data = req_wdata[p*DW +: DW];
                e.mask = ~req_wbe[p*BW +: BW];
                exp_cmd_q.push_back(e);
            end
        end
        @(posedge mem_clk);
        #1;
    endtask

    task automatic push_rsp(input logic [NP-1:0] port, input logic [DW-1:0] data);
        exp_rsp_t r;
        r.port = port;
        r.data = data;
        exp_rsp_q.push_back(r);
    endtask

    logic [NP-1:0] pat [10];
    logic [AW-1:0] a0, a1;

    initial begin
        pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        mem_rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0;
        req_wdata = '0; req_wbe = '0; ddr_calib_done = 1'b0; ddr_cmd_ready = 1'b1;
        ddr_wr_data_rdy = 1'b1; ddr_rd_data = '0; ddr_rd_data_valid = 1'b0;
        repeat (3) @(posedge mem_clk);
        #1;
        check("rst_ctl_outputs", 128'({req_ready, rsp_valid, ddr_cmd, ddr_cmd_en, ddr_addr,
              ddr_wr_data_en, ddr_wr_data_end, ddr_wr_data_mask, err_unexp_rd}), 128'(0));
        check("rst_rsp_rdata", rsp_rdata, 128'(0));
        check("rst_wr_data", ddr_wr_data, 128'(0));
        mem_rst = 1'b0;

        // 1: calibration gate with both ports requesting writes
        a0 = 28'h10; a1 = 28'h20;
        set_port(0, 1'b1, 1'b1, a0, {100'h0, a0}, 16'hFFFF);
        set_port(1, 1'b1, 1'b1, a1, {100'h1, a1}, 16'hFFFF);
        repeat (50) tick(2'b00, "calib_gate_ready");
        ddr_calib_done = 1'b1;
        tick(2'b00, "calib_edge_ready");

        // 2: starvation guard, grant pattern 0,0,0,0,1 repeating
        for (int i = 0; i < 10; i++) begin
            tick(pat[i], "grant_pattern");
            if (pat[i][0]) begin a0 = a0 + 1; set_port(0, 1'b1, 1'b1, a0, {100'h0, a0}, 16'hFFFF); end
            else           begin a1 = a1 + 1; set_port(1, 1'b1, 1'b1, a1, {100'h1, a1}, 16'hFFFF); end
        end
        req_valid = '0;

        // 3: tag routing of in-order read data
        set_port(0, 1'b1, 1'b0, 28'h100, '0, '0);
        tick(2'b01, "rd_A_grant");
        req_valid[0] = 1'b0;
        set_port(1, 1'b1, 1'b0, 28'h200, '0, '0);
        tick(2'b10, "rd_B_grant");
        req_valid[1] = 1'b0;
        set_port(0, 1'b1, 1'b0, 28'h300, '0, '0);
        tick(2'b01, "rd_C_grant");
        req_valid = '0;
        repeat (3) tick(2'b00, "idle_ready");
        push_rsp(2'b01, {4{32'hD0D0_0000}});
        push_rsp(2'b10, {4{32'hD1D1_1111}});
        push_rsp(2'b01, {4{32'hD2D2_2222}});
        ddr_rd_data_valid = 1'b1;
        ddr_rd_data = {4{32'hD0D0_0000}}; tick(2'b00, "ret_ready");
        ddr_rd_data = {4{32'hD1D1_1111}}; tick(2'b00, "ret_ready");
        ddr_rd_data = {4{32'hD2D2_2222}}; tick(2'b00, "ret_ready");
        ddr_rd_data_valid = 1'b0;
        repeat (2) tick(2'b00, "idle_ready");

        // 4: full tag FIFO holds reads, writes continue, pop frees a slot
        for (int i = 0; i < 8; i++) begin
            set_port(0, 1'b1, 1'b0, AW'(28'h400 + i), '0, '0);
            tick(2'b01, "fill_rd_grant");
        end
        set_port(0, 1'b1, 1'b1, 28'h500, {4{32'h5555_AAAA}}, 16'hFFFF);
        set_port(1, 1'b1, 1'b0, 28'h600, '0, '0);
        tick(2'b01, "full_wr_grant");
        req_valid[0] = 1'b0;
        repeat (3) tick(2'b00, "full_rd_held");
        push_rsp(2'b01, 128'hAB);
        ddr_rd_data_valid = 1'b1; ddr_rd_data = 128'hAB;
        tick(2'b10, "pop_frees_rd_grant");
        ddr_rd_data_valid = 1'b0; req_valid = '0;
        repeat (2) tick(2'b00, "idle_ready");
        for (int i = 0; i < 8; i++) begin
            push_rsp((i < 7) ? 2'b01 : 2'b10, 128'(32'hC0 + i));
            ddr_rd_data_valid = 1'b1; ddr_rd_data = 128'(32'hC0 + i);
            tick(2'b00, "drain_ready");
        end
        ddr_rd_data_valid = 1'b0;
        repeat (2) tick(2'b00, "idle_ready");

        // 5: controller backpressure and byte-mask inversion
        ddr_cmd_ready = 1'b0;
        set_port(0, 1'b1, 1'b1, 28'h700, {4{32'hDEAD_BEEF}}, 16'h00FF);
        tick(2'b01, "bp_first_grant");
        set_port(0, 1'b1, 1'b1, 28'h701, {4{32'h1234_5678}}, 16'hFFFF);
        for (int i = 0; i < 10; i++) begin
            tick(2'b00, "bp_ready_held");
            check("bp_no_cmd_en", 128'(ddr_cmd_en), 128'(0));
        end
        check("bp_mask", 128'(ddr_wr_data_mask), 128'(16'hFF00));
        ddr_cmd_ready = 1'b1;
        tick(2'b01, "bp_release_grant");
        req_valid = '0;
        repeat (2) tick(2'b00, "idle_ready");
        check("err_clear_before_rst", 128'(err_unexp_rd), 128'(0));

        // 6: reset with reads outstanding
        for (int i = 0; i < 3; i++) begin
            set_port(0, 1'b1, 1'b0, AW'(28'h800 + i), '0, '0);
            tick(2'b01, "pre_rst_rd_grant");
        end
        req_valid = '0;
        repeat (3) tick(2'b00, "idle_ready");
        mem_rst = 1'b1; ddr_calib_done = 1'b0;
        tick(2'b00, "rst_ready");
        mem_rst = 1'b0;
        ddr_rd_data_valid = 1'b1; ddr_rd_data = 128'hEE;
        tick(2'b00, "stale_ret_ready");
        ddr_rd_data_valid = 1'b0;
        check("err_unexp_rd_set", 128'(err_unexp_rd), 128'(1));
        set_port(0, 1'b1, 1'b1, 28'h900, {4{32'h9999_0000}}, 16'h0F0F);
        repeat (3) tick(2'b00, "recal_gate_ready");
        ddr_calib_done = 1'b1;
        tick(2'b00, "recal_edge_ready");
        tick(2'b01, "recal_grant");
        req_valid = '0;
        repeat (3) tick(2'b00, "idle_ready");
        check("err_unexp_rd_sticky", 128'(err_unexp_rd), 128'(1));

        check("cmd_queue_drained", 128'(exp_cmd_q.size()), 128'(0));
        check("rsp_queue_drained", 128'(exp_rsp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ddr3_native_port_arbiter
`default_nettype wire
